// File: rtl/seq_sub_64bits.sv
// Multi-cycle subtractor: out = in1 - in2 - bin, one SLICE-bit ripple stage reused per clock.
// Latency WIDTH/SLICE cycles after the accepting edge; start is ignored while busy.
module seq_sub_64bits #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic [WIDTH-1:0] out,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] s;
    logic             c;
    logic             last;
    logic             accept;

    // Shared ripple stage: subtraction as in1 + ~in2 + carry, carry = ~borrow.
    always_comb begin
        a_s    = a_q[idx*SLICE +: SLICE];
        b_s    = b_q[idx*SLICE +: SLICE];
        {c, s} = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE{1'b0}}, carry};
    end

    assign last   = (idx == IW'(N - 1));
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    if (accept) state_nxt = RUN;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            out   <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_q   <= in1;
            b_q   <= in2;
            carry <= ~bin;
            idx   <= '0;
            out   <= '0;
        end else if (state == RUN) begin
            out[idx*SLICE +: SLICE] <= s;
            carry <= c;
            idx   <= idx + 1'b1;
            if (last) begin
                bout <= ~c;
                // s[SLICE-1] is the final result MSB being written on this edge.
                ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s[SLICE-1] != a_q[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_seq_sub_64bits.sv
// Self-checking bench for seq_sub_64bits: directed table, handshake corner cases, random regression.
module tb_seq_sub_64bits;

    typedef struct {
        logic [63:0] in1;
        logic [63:0] in2;
        logic        bin;
        logic [63:0] out;
        logic        bout;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        bin;
    logic [63:0] out;
    logic        bout;
    logic        ovf;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    vec_t sb[$];

    seq_sub_64bits #(.WIDTH(64), .SLICE(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .bin   (bin),
        .out   (out),
        .bout  (bout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [63:0] a, input logic [63:0] b, input logic bi);
        vec_t v;
        logic [64:0] d;
        d      = {1'b0, a} - {1'b0, b} - {64'd0, bi};
        v.in1  = a;
        v.in2  = b;
        v.bin  = bi;
        v.out  = d[63:0];
        v.bout = d[64];
        v.ovf  = (a[63] != b[63]) && (d[63] != a[63]);
        return v;
    endfunction

    // Drives one operation, pushes its expectation, then pops and compares when done rises.
    task automatic run_op(input vec_t e, input bit disturb);
        int   cyc;
        bit   got;
        vec_t x;
        @(negedge clk);
        in1   = e.in1;
        in2   = e.in2;
        bin   = e.bin;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        check("accept_busy_done", {62'd0, busy, done}, 64'd2);
        cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) cyc++;
                if (disturb) begin
                    in1   = {$urandom, $urandom};
                    in2   = {$urandom, $urandom};
                    bin   = 1'($urandom_range(0, 1));
                    start = 1'($urandom_range(0, 1));
                end
            end
        end
        start = 1'b0;
        check("done_timeout", {63'd0, got}, 64'd1);
        check("busy_cycles", 64'(cyc), 64'd4);
        x = sb.pop_front();
        check("result", {out[63:0]}, x.out);
        check("flags", {62'd0, bout, ovf}, {62'd0, x.bout, x.ovf});
    endtask

    vec_t tbl[6];
    vec_t v;

    initial begin
        tbl[0] = '{64'd100, 64'd58, 1'b0, 64'd42, 1'b0, 1'b0};
        tbl[1] = '{64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
        tbl[2] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        tbl[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        tbl[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        bin   = 1'b0;
        #3;
        check("reset_out", out, 64'd0);
        check("reset_flags", {60'd0, bout, ovf, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle with start low holds reset values.
        repeat (3) @(negedge clk);
        check("idle_hold", {59'd0, |out, bout, ovf, busy, done}, 64'd0);

        // Reset two cycles into a run clears everything asynchronously.
        @(negedge clk);
        in1   = 64'd500;
        in2   = 64'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_out", out, 64'd0);
        check("async_reset_flags", {60'd0, bout, ovf, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(tbl[0], 1'b0);

        for (int i = 0; i < 6; i++) run_op(tbl[i], 1'b0);

        // DONE holds its results while start stays low.
        repeat (3) @(negedge clk);
        check("done_hold", {61'd0, done, bout, ovf}, {61'd0, 1'b1, tbl[5].bout, tbl[5].ovf});
        check("done_hold_out", out, tbl[5].out);

        // Start pulses and operand churn mid-run do not affect the latched operation.
        run_op(tbl[3], 1'b1);
        run_op(tbl[1], 1'b1);

        for (int i = 0; i < 10000; i++) begin
            v = model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            run_op(v, (i % 16) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
